// File: rtl/mod_exp_engine.sv
// Modular exponentiator: result = base^exponent mod modulus using right-to-left
// square-and-multiply over a shared restoring shift-subtract reduction unit.
module mod_exp_engine #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] result
);
  localparam int unsigned DW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(2 * WIDTH) + 1;

  typedef enum logic [2:0] {IDLE, CHECK, RED_B, MUL, SQR, DONE} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   base_r, e_r, n_r, acc, b;
  logic [DW-1:0]      opnd;
  logic [WIDTH:0]     rem;
  logic [CNT_W-1:0]   step, bit_idx;

  logic [WIDTH:0]     rem_sh, rem_next;
  logic [WIDTH-1:0]   b_upd, acc_upd, mul_x;
  logic [DW-1:0]      product;
  logic               last;

  // One restoring-division step per cycle; remainder is one bit wider than n
  always_comb begin
    rem_sh   = {rem[WIDTH-1:0], opnd[DW-1]};
    rem_next = rem_sh;
    if (rem_sh >= {1'b0, n_r}) rem_next = rem_sh - {1'b0, n_r};
    last    = (step == CNT_W'(DW - 1));
    b_upd   = b;
    acc_upd = acc;
    if (state == RED_B || state == SQR) b_upd = rem_next[WIDTH-1:0];
    if (state == MUL && e_r[0])         acc_upd = rem_next[WIDTH-1:0];
    // Operand for the next phase: b*b after MUL, acc*b after RED_B or SQR
    mul_x   = (state == MUL) ? b_upd : acc_upd;
    product = DW'(mul_x) * DW'(b_upd);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = CHECK;
      CHECK: state_next = (n_r == '0) ? DONE : RED_B;
      RED_B: if (last) state_next = MUL;
      MUL:   if (last) state_next = SQR;
      SQR:   if (last) state_next = (bit_idx == CNT_W'(WIDTH - 1)) ? DONE : MUL;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_r  <= '0;
      e_r     <= '0;
      n_r     <= '0;
      acc     <= '0;
      b       <= '0;
      opnd    <= '0;
      rem     <= '0;
      step    <= '0;
      bit_idx <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_r <= base;
            e_r    <= exponent;
            n_r    <= modulus;
            busy   <= 1'b1;
            error  <= 1'b0;
          end
        end
        CHECK: begin
          acc     <= WIDTH'(1);
          opnd    <= {{WIDTH{1'b0}}, base_r};
          rem     <= '0;
          step    <= '0;
          bit_idx <= '0;
        end
        RED_B, MUL, SQR: begin
          step <= step + CNT_W'(1);
          opnd <= opnd << 1;
          rem  <= rem_next;
          if (last) begin
            step <= '0;
            rem  <= '0;
            opnd <= product;
            b    <= b_upd;
            acc  <= acc_upd;
            if (state == MUL) e_r <= e_r >> 1;
            if (state == SQR) bit_idx <= bit_idx + CNT_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b1;
          error <= (n_r == '0);
          if (n_r == '0)      result <= '0;
          else if (acc >= n_r) result <= acc - n_r;
          else                 result <= acc;
        end
        default: ;
      endcase
      if (state_next == DONE) busy <= 1'b0;
    end
  end

endmodule
